// File: rtl/ex_muldiv_if.sv
// Issue/write-back bundle between the EX stage and the RV32M multi-cycle unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] reg1_i;
  logic [XLEN-1:0] reg2_i;
  logic [4:0]      wd_i;
  logic            flush_i;
  logic            stall_req_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      wd_o;
  logic            wreg_o;

  modport slave (
    input  start_i, funct3_i, reg1_i, reg2_i, wd_i, flush_i,
    output stall_req_o, busy_o, done_o, result_o, wd_o, wreg_o
  );

  modport master (
    output start_i, funct3_i, reg1_i, reg2_i, wd_i, flush_i,
    input  stall_req_o, busy_o, done_o, result_o, wd_o, wreg_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle
// on sign-stripped magnitudes; sign fix-up is folded into the final CALC step.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  ex_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic              neg1, neg2;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        wd_q;
  logic              stall;

  logic              sgn1, sgn2, in_neg1, in_neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;

  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_nxt, prod_fix;
  logic              qbit;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fix, rem_fix, fin_val;

  // Operand decode at issue time
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (bus.funct3_i)
      3'b001, 3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'b010:                 sgn1 = 1'b1;
      default: ;
    endcase
    in_neg1     = sgn1 & bus.reg1_i[XLEN-1];
    in_neg2     = sgn2 & bus.reg2_i[XLEN-1];
    mag1        = in_neg1 ? -bus.reg1_i : bus.reg1_i;
    mag2        = in_neg2 ? -bus.reg2_i : bus.reg2_i;
    div_zero    = bus.funct3_i[2] & (bus.reg2_i == '0);
    div_ovf     = bus.funct3_i[2] & ~bus.funct3_i[0]
                & (bus.reg1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.reg2_i == '1);
    special     = div_zero | div_ovf;
    if (bus.funct3_i[1])
      special_val = div_zero ? bus.reg1_i : '0;
    else
      special_val = div_zero ? '1 : bus.reg1_i;
  end

  // One iteration step, plus the sign-corrected result of that step
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt  = {sum, acc[XLEN-1:1]};
    rem_sh   = {rem, acc[XLEN-1]};
    diff     = rem_sh - {1'b0, opb};
    qbit     = ~diff[XLEN];
    rem_nxt  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt  = {acc[XLEN-2:0], qbit};
    prod_fix = (neg1 ^ neg2) ? -mul_nxt : mul_nxt;
    quo_fix  = (neg1 ^ neg2) ? -quo_nxt : quo_nxt;
    rem_fix  = neg1 ? -rem_nxt : rem_nxt;
    if (op == 3'b000)
      fin_val = prod_fix[XLEN-1:0];
    else if (!op[2])
      fin_val = prod_fix[2*XLEN-1:XLEN];
    else
      fin_val = op[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (rdy)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (bus.start_i && !bus.flush_i) begin
        stall     = 1'b1;
        state_nxt = special ? FIN : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (bus.flush_i)
          state_nxt = IDLE;
        else if (cnt == CNT_W'(1))
          state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      result_q <= '0;
      wd_q     <= '0;
    end else if (rdy) begin
      if (state == IDLE && bus.start_i && !bus.flush_i) begin
        op   <= bus.funct3_i;
        wd_q <= bus.wd_i;
        neg1 <= in_neg1;
        neg2 <= in_neg2;
        // Multiply shifts the multiplier (rs2) out of acc; divide shifts the dividend (rs1)
        acc  <= {{XLEN{1'b0}}, bus.funct3_i[2] ? mag1 : mag2};
        opb  <= bus.funct3_i[2] ? mag2 : mag1;
        rem  <= '0;
        cnt  <= CNT_W'(XLEN);
        if (special)
          result_q <= special_val;
      end else if (state == CALC && !bus.flush_i) begin
        acc <= op[2] ? {{XLEN{1'b0}}, quo_nxt} : mul_nxt;
        rem <= rem_nxt;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          result_q <= fin_val;
      end
    end
  end

  assign bus.stall_req_o = stall;
  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = (state == FIN);
  assign bus.wreg_o      = (state == FIN);
  assign bus.result_o    = result_q;
  assign bus.wd_o        = wd_q;
endmodule
